regwb_arbiter: RTL and testbench
================================

Name: regwb_arbiter

Overview:
Write-back arbiter for the 32x32 register file's single write port. Shares that port between up to NUM_REQ producers (ALU, load unit, mul/div) with valid/ready handshakes and round-robin fairness. Registers the winning write for one cycle before driving the register file's write port. Exposes the in-flight write for hazard and forwarding logic.

Parameters:
NUM_REQ, 3, number of write requesters
ADDR_W, 5, register index width
DATA_W, 32, write data width
LOCK_MAX, 4, maximum consecutive cycles in LOCK before forced release (used only with REGWB_LOCK_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept, combinational
req_addr  in  NUM_REQ*ADDR_W  destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  write data, same packing
req_lock  in  NUM_REQ  hold grant after this beat (present only with REGWB_LOCK_EN)
rf_hold  in  1  block all grants this cycle
rf_reg_write  out  1  to register file reg_write
rf_write_reg  out  ADDR_W  to register file write_reg
rf_write_data  out  DATA_W  to register file write_data
inflight_valid  out  1  a nonzero-destination write is on the port this cycle
inflight_addr  out  ADDR_W  equals rf_write_reg
inflight_data  out  DATA_W  equals rf_write_data

Behaviour:
- Reset, asynchronous, while rst_n=0: rf_reg_write=0, rf_write_reg=0, rf_write_data=0, inflight_valid=0, RR pointer=0, FSM=ARB, lock counter=0. req_ready=0 while in reset.
- Accept: beat accepted when req_valid[i] & req_ready[i]. At most one req_ready bit is high per cycle.
- req_ready depends on req_valid. Only the winning valid requester sees ready. If no requester is valid, all ready bits are 0.
- Arbitration, ARB state: search from ptr upward with wrap-around. First valid requester wins. After an accept by i, ptr <= (i+1) mod NUM_REQ.
- Fairness bound: with rf_hold=0, a continuously valid requester is granted within NUM_REQ cycles.
- rf_hold=1: all req_ready=0 and ptr unchanged. The write already in the output stage still completes.
- Latency: a beat accepted in cycle N appears on rf_* in cycle N+1 for exactly one cycle. The register file commits it at the end of N+1.
- Back-to-back accepts give rf_reg_write=1 every cycle.
- No accept in cycle N: rf_reg_write=0, rf_write_reg=0, rf_write_data=0 in N+1.
- Destination 0: the beat is accepted and advances ptr, but in N+1 rf_reg_write=0, inflight_valid=0 and addr/data are 0. The port slot is consumed.
- inflight_valid = rf_reg_write.
- Reset mid-operation: an accepted but unwritten beat is dropped. rf_reg_write falls immediately on rst_n falling.

Optional Feature:
REGWB_LOCK_EN. Defined:
- req_lock port exists. FSM states are ARB and LOCK.
- ARB->LOCK on an accepted beat from i with req_lock[i]=1. owner <= i, lock counter <= 1.
- In LOCK, only owner can be granted and all other ready bits are 0. Lock counter increments every LOCK cycle, including idle cycles and rf_hold cycles.
- LOCK->ARB on either of: an accepted owner beat with req_lock=0, or the counter reaching LOCK_MAX.
- The forced release takes effect the next cycle, without granting in the release cycle unless the owner beat ends the lock.
- ptr <= owner+1 on release.
- Reset in LOCK returns to ARB.

Not defined: no req_lock port, FSM fixed in ARB, lock counter absent.

Decomposition:
- Package regwb_pkg: ADDR_W, DATA_W, NUM_REQ defaults; requester indices REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2; FSM state typedef {ARB, LOCK}.
- One combinational sub-module rr_pick: request vector plus pointer in, one-hot grant plus index out. Reused by other shared-resource arbiters.

Test Plan:
- Reset: hold rst_n=0 with all valid -> all outputs 0 and all ready 0. Release, all valid -> requester 0 granted first; rf_reg_write=1 next cycle.
- Round-robin: all valid continuously, addrs 1/2/3, data 0x11/0x22/0x33 -> grants 0,1,2,0,1,2. rf_write_reg sequence 1,2,3,... each delayed one cycle; rf_reg_write held at 1.
- Zero destination: only requester 1 valid, addr 0, data 0xDEADBEEF -> ready[1]=1; next cycle rf_reg_write=0, inflight_valid=0; following grant search starts at 2.
- Hold: all valid, rf_hold=1 for 3 cycles after a grant to 0 -> ready=0 for 3 cycles; the pending write still appears once; after release, requester 1 is granted.
- Lock (macro on, LOCK_MAX=4): requester 2 beats addr 2 lock=1 then addr 3 lock=0, requester 0 valid throughout -> 2,2 granted back-to-back, then 0. Separately, requester 2 locks then goes idle -> forced release after 4 cycles, then 0 granted.
- Async reset mid-write: accept addr 5 data 0xA5A5A5A5, drop rst_n before the next edge -> rf_reg_write=0 immediately; register 5 is not written.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file write-back arbiter and its round-robin picker.
package regwb_pkg;

  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LOCK_MAX = 4;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regwb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module rr_pick
  import regwb_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found_s;
  logic hit_s;
  int   slot_s;

  // scan slots ptr, ptr+1, ... modulo N and keep only the first hit
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    slot_s  = 0;
    for (int off = 0; off < N; off++) begin
      slot_s        = int'(ptr) + off;
      slot_s        = (slot_s >= N) ? (slot_s - N) : slot_s;
      hit_s         = ~found_s & req[slot_s];
      grant[slot_s] = hit_s;
      idx           = hit_s ? IDX_W'(slot_s) : idx;
      found_s       = found_s | hit_s;
    end
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Round-robin write-back arbiter for the register file write port, one-cycle output stage.
// Optional requester lock (req_lock port, ARB/LOCK FSM) is built when REGWB_LOCK_EN is defined.
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
`ifdef REGWB_LOCK_EN
  ,
  parameter int LOCK_MAX = DEF_LOCK_MAX
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef REGWB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  input  logic                      rf_hold,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_write_reg,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      inflight_valid,
  output logic [ADDR_W-1:0]         inflight_addr,
  output logic [DATA_W-1:0]         inflight_data
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   idx_s;
  logic [NUM_REQ-1:0] open_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  logic               wr_en_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : (v + IDX_W'(1));
  endfunction

  assign open_s = rf_hold ? '0 : req_valid;

`ifdef REGWB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state_r;
  logic [IDX_W-1:0]   owner_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               cap_s;
  logic               lock_beat_s;
  logic [NUM_REQ-1:0] owner_mask_s;

  // at the cap only a lock-ending owner beat may still be granted
  assign cap_s        = (cnt_r == CNT_W'(LOCK_MAX));
  assign lock_beat_s  = req_lock[idx_s];
  assign owner_mask_s = (NUM_REQ'(1) << owner_r) & {NUM_REQ{~(cap_s & req_lock[owner_r])}};
  assign elig_s       = (state_r == LOCK) ? (open_s & owner_mask_s) : open_s;
`else
  assign elig_s = open_s;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (elig_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (idx_s)
  );

  assign req_ready  = rst_n ? grant_s : '0;
  assign accept_s   = |req_ready;
  assign sel_addr_s = req_addr[idx_s*ADDR_W +: ADDR_W];
  assign sel_data_s = req_data[idx_s*DATA_W +: DATA_W];
  assign wr_en_s    = accept_s & (sel_addr_s != '0);

  // output stage: accepted beat drives the port for exactly one cycle; x0 writes become bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_reg_write  <= wr_en_s;
      rf_write_reg  <= wr_en_s ? sel_addr_s : '0;
      rf_write_data <= wr_en_s ? sel_data_s : '0;
    end
  end

  assign inflight_valid = rf_reg_write;
  assign inflight_addr  = rf_write_reg;
  assign inflight_data  = rf_write_data;

`ifdef REGWB_LOCK_EN
  // pointer and lock FSM: release hands priority to the requester after the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= '0;
      state_r <= ARB;
      owner_r <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ARB: begin
          if (accept_s) begin
            ptr_r <= wrap_inc(idx_s);
            if (lock_beat_s) begin
              state_r <= LOCK;
              owner_r <= idx_s;
              cnt_r   <= CNT_W'(1);
            end else begin
              state_r <= ARB;
            end
          end else begin
            ptr_r <= ptr_r;
          end
        end
        LOCK: begin
          if ((accept_s && !lock_beat_s) || cap_s) begin
            state_r <= ARB;
            ptr_r   <= wrap_inc(owner_r);
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ARB;
          cnt_r   <= '0;
        end
      endcase
    end
  end
`else
  // round-robin pointer advances past each accepted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= wrap_inc(idx_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_regwb_arbiter;
  import regwb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
`ifdef REGWB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif
  logic            rf_hold = 1'b0;
  logic            rf_reg_write;
  logic [AW-1:0]   rf_write_reg;
  logic [DW-1:0]   rf_write_data;
  logic            inflight_valid;
  logic [AW-1:0]   inflight_addr;
  logic [DW-1:0]   inflight_data;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  regwb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
`ifdef REGWB_LOCK_EN
    .req_lock       (req_lock),
`endif
    .rf_hold        (rf_hold),
    .rf_reg_write   (rf_reg_write),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data),
    .inflight_valid (inflight_valid),
    .inflight_addr  (inflight_addr),
    .inflight_data  (inflight_data)
  );

  // Reference: first valid requester scanning upward from the pointer with wrap-around.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic set_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h11 * (i + 1)));
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rf_hold   = 1'b0;
`ifdef REGWB_LOCK_EN
    req_lock  = '0;
`endif
    #10;
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_all();
    #10;
    total++;
    if ({rf_reg_write, rf_write_reg, rf_write_data, inflight_valid} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%h iv=%b want all zero", rf_reg_write, rf_write_reg, rf_write_data, inflight_valid);
    end
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 5'd1, 32'h11}) begin
      bad++;
      $display("FAIL reset_first_write: got we=%b reg=%0d data=%h want 1/1/11", rf_reg_write, rf_write_reg, rf_write_data);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    set_all();
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if (req_ready !== (3'b001 << (k % 3))) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 3'b001 << (k % 3));
      end
      @(posedge clk); #1;
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, AW'(k % 3 + 1), DW'(32'h11 * (k % 3 + 1))}) begin
        bad++;
        $display("FAIL rr_write[%0d]: got we=%b reg=%0d data=%h want reg=%0d", k, rf_reg_write, rf_write_reg, rf_write_data, k % 3 + 1);
      end
    end
  endtask

  task automatic test_zero_dest();
    reset_dut();
    set_req(REQ_LOAD, 1'b1, 5'd0, 32'hDEADBEEF);
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL zero_grant: got %b want 010", req_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({rf_reg_write, inflight_valid, rf_write_reg, rf_write_data} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      bad++;
      $display("FAIL zero_write: got we=%b iv=%b reg=%0d data=%h want all zero", rf_reg_write, inflight_valid, rf_write_reg, rf_write_data);
    end
    set_all();
    #1;
    total++;
    if (req_ready !== 3'b100) begin
      bad++;
      $display("FAIL zero_next_ptr: got %b want 100", req_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({rf_reg_write, rf_write_reg} !== {1'b1, 5'd3}) begin
      bad++;
      $display("FAIL zero_next_write: got we=%b reg=%0d want 1/3", rf_reg_write, rf_write_reg);
    end
  endtask

  task automatic test_hold();
    reset_dut();
    set_all();
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL hold_pre_grant: got %b want 001", req_ready);
    end
    @(posedge clk); #1;
    rf_hold = 1'b1;
    #1;
    total++;
    if ({req_ready, rf_reg_write, rf_write_reg} !== {3'b000, 1'b1, 5'd1}) begin
      bad++;
      $display("FAIL hold_pending: got ready=%b we=%b reg=%0d want 000/1/1", req_ready, rf_reg_write, rf_write_reg);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if ({req_ready, rf_reg_write} !== {3'b000, 1'b0}) begin
        bad++;
        $display("FAIL hold_cycle[%0d]: got ready=%b we=%b want 000/0", k, req_ready, rf_reg_write);
      end
    end
    rf_hold = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL hold_release: got %b want 010", req_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({rf_reg_write, rf_write_reg} !== {1'b1, 5'd2}) begin
      bad++;
      $display("FAIL hold_release_write: got we=%b reg=%0d want 1/2", rf_reg_write, rf_write_reg);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    set_req(REQ_ALU, 1'b1, 5'd5, 32'hA5A5A5A5);
    @(posedge clk); #1;
    total++;
    if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
      bad++;
      $display("FAIL async_pre: got we=%b reg=%0d data=%h want 1/5/a5a5a5a5", rf_reg_write, rf_write_reg, rf_write_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rf_reg_write, inflight_valid, rf_write_reg, rf_write_data, req_ready} !== {1'b0, 1'b0, 5'd0, 32'd0, 3'b000}) begin
      bad++;
      $display("FAIL async_drop: got we=%b iv=%b reg=%0d data=%h ready=%b want all zero", rf_reg_write, inflight_valid, rf_write_reg, rf_write_data, req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rf_reg_write !== 1'b0) begin
      bad++;
      $display("FAIL async_no_commit: got we=%b want 0", rf_reg_write);
    end
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_random();
    int            g;
    logic          we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [N-1:0]  er;
    reset_dut();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) set_req(i, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)), DW'($urandom));
      rf_hold = ($urandom_range(0, 5) == 0);
      #1;
      g  = rf_hold ? -1 : model_pick(req_valid, m_ptr);
      er = (g >= 0) ? (3'b001 << g) : 3'b000;
      total++;
      if (req_ready !== er) begin
        bad++;
        $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, er);
      end
      we = 1'b0;
      ea = '0;
      ed = '0;
      if (g >= 0) begin
        we    = (req_addr[g*AW +: AW] != 5'd0);
        ea    = we ? req_addr[g*AW +: AW] : 5'd0;
        ed    = we ? req_data[g*DW +: DW] : 32'd0;
        m_ptr = (g + 1) % N;
      end
      @(posedge clk); #1;
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data, inflight_valid, inflight_addr, inflight_data} !== {we, ea, ed, we, ea, ed}) begin
        bad++;
        $display("FAIL rand_write[%0d]: got we=%b reg=%0d data=%h iv=%b want we=%b reg=%0d data=%h", c, rf_reg_write, rf_write_reg, rf_write_data, inflight_valid, we, ea, ed);
      end
    end
  endtask

`ifdef REGWB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0]  exp_ready [10];
    logic [AW-1:0] exp_reg   [10];
    exp_ready = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    exp_reg   = '{5'd9, 5'd2, 5'd3, 5'd7, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: set_req(REQ_LOAD, 1'b1, 5'd9, 32'h9);
        1: begin
          set_req(REQ_LOAD, 1'b0, 5'd0, 32'h0);
          set_req(REQ_ALU, 1'b1, 5'd7, 32'h70);
          set_req(REQ_MULDIV, 1'b1, 5'd2, 32'h2);
          req_lock[REQ_MULDIV] = 1'b1;
        end
        2: begin
          set_req(REQ_MULDIV, 1'b1, 5'd3, 32'h3);
          req_lock[REQ_MULDIV] = 1'b0;
        end
        4: begin
          set_req(REQ_ALU, 1'b0, 5'd7, 32'h70);
          set_req(REQ_MULDIV, 1'b1, 5'd4, 32'h4);
          req_lock[REQ_MULDIV] = 1'b1;
        end
        5: begin
          set_req(REQ_ALU, 1'b1, 5'd7, 32'h70);
          set_req(REQ_MULDIV, 1'b0, 5'd0, 32'h0);
        end
        default: ;
      endcase
      #1;
      total++;
      if (req_ready !== exp_ready[c]) begin
        bad++;
        $display("FAIL lock_ready[%0d]: got %b want %b", c, req_ready, exp_ready[c]);
      end
      @(posedge clk); #1;
      total++;
      if ({rf_reg_write, rf_write_reg} !== {(exp_reg[c] != 5'd0), exp_reg[c]}) begin
        bad++;
        $display("FAIL lock_write[%0d]: got we=%b reg=%0d want reg=%0d", c, rf_reg_write, rf_write_reg, exp_reg[c]);
      end
    end
    req_lock = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_zero_dest();
    test_hold();
    test_async_reset();
`ifdef REGWB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
